send_control_mc: RTL
====================

Name: send_control_mc

Overview:
- Parametrised multi-channel successor to the single-stream send controller.
- Issues one-cycle start_sending pulses to the frame transmitter, tracks busy, and enforces a programmable inter-frame gap.
- Steps segment_num up to a switch-selected maximum, then round-robins txid over the enabled channels.
- Sits between board switches and the Ethernet TX frame builder.

Parameters:
- NUM_CH, 4, number of logical channels (1..16); txid = ID_BASE + channel index.
- SEG_W, 16, width of segment_num.
- ID_BASE, 8'h00, txid of channel 0.
- GAP_W, 16, width of gap_cycles.
- TIMEOUT, 1024, cycles to wait for busy rise (used only with BUSY_TIMEOUT_EN).

Ports:
- clk125MHz  in  1  system clock, 125 MHz.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  run request; sampled only in IDLE and at frame end.
- switches  in  8  [3:0]=k, max segment count = 2^k (k clamped to SEG_W); [7:4] reserved, ignored.
- ch_mask  in  NUM_CH  channel enable mask.
- gap_cycles  in  GAP_W  idle cycles between busy fall and next start.
- busy  in  1  transmitter busy, high while a frame is in flight.
- segment_num  out  SEG_W  segment index of current frame.
- txid  out  8  channel id of current frame.
- aux  out  8  round counter; increments when the round-robin wraps to the lowest enabled channel.
- start_sending  out  1  one-cycle start strobe.
- err  out  1  one-cycle timeout strobe (tied 0 without BUSY_TIMEOUT_EN).

Behaviour:
- Reset (async, rstn=0): state=IDLE; segment_num=0, aux=0, start_sending=0, err=0, gap counter=0; txid=ID_BASE+index of lowest set ch_mask bit, else ID_BASE.
- States and transitions:
  - IDLE: if enable && !busy && |ch_mask, go to START.
  - START: start_sending=1 for exactly this cycle; go to WAIT_HI.
  - WAIT_HI: wait for busy=1, then go to WAIT_LO.
  - WAIT_LO: wait for busy=0; load gap counter with gap_cycles; go to GAP.
  - GAP: decrement each cycle; at 0, advance the segment/channel (rules below); then go to START if enable && |ch_mask, else IDLE.
- gap_cycles=0: GAP lasts one cycle. Start-to-start spacing = 1 + busy-high time + gap + 2 cycles.
- Advance rules:
  - If segment_num < 2^k-1: segment_num+1.
  - Else: segment_num=0, txid moves to the next set bit of ch_mask above the current channel.
  - Wrap to the lowest set bit increments aux (mod 256).
  - k=0: every frame advances the channel.
- Single channel in ch_mask: txid is constant; aux increments every 2^k frames.
- ch_mask changed mid-round: sampled only at advance. If the current channel is cleared, it finishes its segment run.
- switches changed mid-run: the new max applies at the next compare. If segment_num already exceeds the new max-1, treat as the wrap condition.
- enable low mid-frame: the frame completes, including GAP, then IDLE. Counters hold, and resume from the held values.
- busy high in START: ignored, still go to WAIT_HI. WAIT_HI exits on the next cycle.
- Outputs are registered. segment_num and txid are stable from the start_sending cycle until advance.

Optional Feature:
- BUSY_TIMEOUT_EN defined:
  - WAIT_HI counts cycles; if busy is still 0 after TIMEOUT cycles, pulse err for one cycle and go to START.
  - The retry resends the same segment_num and txid; no advance.
- Undefined: no counter, WAIT_HI waits indefinitely, err tied 0.

Test Plan:
- Reset release, switches=8'h02, ch_mask=4'b0001, enable=1, busy model 10 cycles high 3 cycles after start -> segment_num 0,1,2,3,0; txid=8'h00 throughout; aux 0→1 at the 5th start.
- ch_mask=4'b1010, switches=8'h00 -> txid sequence 01,03,01,03; aux increments at each return to 01.
- gap_cycles=5, busy high 10 cycles -> start-to-start spacing = 1+10+5+2 cycles (measure against the exact busy model); gap_cycles=0 -> minimum spacing.
- enable dropped during WAIT_LO -> one final advance, then IDLE with start_sending=0; enable re-raised -> resumes at the next segment.
- rstn pulsed low during GAP -> all outputs return to reset values immediately (asynchronously); no start_sending until enable is re-sampled.
- BUSY_TIMEOUT_EN, TIMEOUT=16, busy held 0 -> err pulse 16 cycles after start, start_sending repeats with the same segment_num; without the macro, no err and no second start.

Source files
------------

// File: rtl/send_control_mc.sv
// send_control_mc
//   Multi-channel send controller. Issues one-cycle start_sending strobes to
//   the Ethernet TX frame builder, waits for the transmitter busy handshake,
//   inserts a programmable inter-frame gap, steps segment_num up to 2^k-1
//   (k = switches[3:0]) and then round-robins txid over the channels enabled
//   in ch_mask. aux counts completed rounds.
//
// Optional feature macro: BUSY_TIMEOUT_EN
//   Defined   : WAIT_HI gives up after TIMEOUT cycles without busy, pulses err
//               and resends the same segment/channel.
//   Undefined : WAIT_HI waits indefinitely, err is tied low.
//
// Ports:
//   clk125MHz     in   system clock, 125 MHz
//   rstn          in   asynchronous active-low reset
//   enable        in   run request, sampled in IDLE and at frame end
//   switches      in   [3:0] = k, max segment count 2^k; [7:4] ignored
//   ch_mask       in   channel enable mask
//   gap_cycles    in   idle cycles between busy fall and next start
//   busy          in   transmitter busy
//   segment_num   out  segment index of current frame
//   txid          out  channel id of current frame (ID_BASE + channel)
//   aux           out  round counter
//   start_sending out  one-cycle start strobe
//   err           out  one-cycle busy timeout strobe
module send_control_mc #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned SEG_W   = 16,
    parameter logic [7:0]  ID_BASE = 8'h00,
    parameter int unsigned GAP_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk125MHz,
    input  logic              rstn,
    input  logic              enable,
    input  logic [7:0]        switches,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [GAP_W-1:0]  gap_cycles,
    input  logic              busy,
    output logic [SEG_W-1:0]  segment_num,
    output logic [7:0]        txid,
    output logic [7:0]        aux,
    output logic              start_sending,
    output logic              err
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, GAP} state_t;

    state_t            state;
    logic [CH_W-1:0]   ch_idx;
    logic [GAP_W-1:0]  gap_cnt;

    logic              lo_found, nx_found;
    logic [CH_W-1:0]   lo_idx, nx_idx;
    logic [NUM_CH-1:0] mask_sh;
    logic [SEG_W-1:0]  seg_last;
    logic              seg_wrap;

    // Lowest enabled channel, and the next enabled channel above the current one.
    always_comb begin
        lo_found = 1'b0;
        lo_idx   = '0;
        nx_found = 1'b0;
        nx_idx   = '0;
        mask_sh  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            mask_sh = ch_mask >> i;
            if (mask_sh[0]) begin
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = CH_W'(i);
                end
                if (!nx_found && (i > 32'(ch_idx))) begin
                    nx_found = 1'b1;
                    nx_idx   = CH_W'(i);
                end
            end
        end
    end

    // k >= SEG_W shifts the one out, so the subtraction yields all-ones:
    // that is the clamp to SEG_W. '>=' also catches a segment_num already
    // beyond a freshly lowered maximum.
    always_comb begin
        seg_last = (SEG_W'(1) << switches[3:0]) - SEG_W'(1);
        seg_wrap = (segment_num >= seg_last);
    end

    logic unused_sw;
    assign unused_sw = &{1'b0, switches[7:4]};

`ifdef BUSY_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;
    logic            err_r;
    assign err = err_r;
`else
    logic unused_to;
    assign unused_to = &{1'b0, TIMEOUT[0]};
    assign err = 1'b0;
`endif

    always_ff @(posedge clk125MHz or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            segment_num   <= '0;
            aux           <= '0;
            start_sending <= 1'b0;
            gap_cnt       <= '0;
            ch_idx        <= lo_idx;
            txid          <= ID_BASE + 8'(lo_idx);
`ifdef BUSY_TIMEOUT_EN
            to_cnt        <= '0;
            err_r         <= 1'b0;
`endif
        end else begin
            start_sending <= 1'b0;
`ifdef BUSY_TIMEOUT_EN
            err_r         <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (enable && !busy && |ch_mask) begin
                        state         <= START;
                        start_sending <= 1'b1;
                    end
                end
                START: begin
                    state <= WAIT_HI;
`ifdef BUSY_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                WAIT_HI: begin
                    if (busy) begin
                        state <= WAIT_LO;
`ifdef BUSY_TIMEOUT_EN
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        // Retry without advancing segment/channel.
                        err_r         <= 1'b1;
                        state         <= START;
                        start_sending <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                WAIT_LO: begin
                    if (!busy) begin
                        gap_cnt <= gap_cycles;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        if (seg_wrap) begin
                            segment_num <= '0;
                            if (nx_found) begin
                                ch_idx <= nx_idx;
                                txid   <= ID_BASE + 8'(nx_idx);
                            end else if (lo_found) begin
                                ch_idx <= lo_idx;
                                txid   <= ID_BASE + 8'(lo_idx);
                                aux    <= aux + 8'd1;
                            end
                        end else begin
                            segment_num <= segment_num + 1'b1;
                        end
                        if (enable && |ch_mask) begin
                            state         <= START;
                            start_sending <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
